// File: rtl/bw_io_ddr_mclk_pkg.sv
// Shared types and constants for the DDR memory-clock pad controller.
// Holds the per-channel state encoding and the preamble/postamble counter width.
package bw_io_ddr_mclk_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        CH_OFF,
        CH_START,
        CH_RUN,
        CH_STOP
    } ch_state_t;

    // The counter saturates so a long preamble can never wrap back to zero.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/bw_io_ddr_mclk_ch.sv
// One memory-clock pad channel: enable FSM with preamble/postamble counter,
// registered pad controls, and the gated ODT delay line.
module bw_io_ddr_mclk_ch
    import bw_io_ddr_mclk_pkg::*;
#(
    parameter int PRE_CYC  = 4,
    parameter int POST_CYC = 2,
    parameter int ODT_DLY  = 2
) (
    input  logic clk,
    input  logic rst_l,
    input  logic ph,
    input  logic en_req,
    input  logic odt_req,
    output logic pad_data,
    output logic pad_oe,
    output logic pad_odt,
    output logic ch_run,
    output logic in_trans
);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_CYC - 1);

    ch_state_t          state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [ODT_DLY-1:0] odt_pipe, odt_nx;
    logic               oe_nx;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state    <= CH_OFF;
            cnt      <= '0;
            pad_oe   <= 1'b0;
            pad_data <= 1'b0;
            ch_run   <= 1'b0;
            odt_pipe <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            pad_oe   <= oe_nx;
            pad_data <= (state_nx == CH_RUN) & ~ph;
            ch_run   <= (state_nx == CH_RUN);
            odt_pipe <= odt_nx;
        end
    end

    // RUN is only entered or left after a ph=1 cycle, so every clock high half is complete.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            CH_OFF: begin
                if (en_req) begin
                    state_nx = CH_START;
                    cnt_nx   = '0;
                end
            end
            CH_START: begin
                cnt_nx = cnt_inc(cnt);
                if (cnt >= PRE_LAST && ph) begin
                    state_nx = CH_RUN;
                    cnt_nx   = '0;
                end
            end
            CH_RUN: begin
                if (!en_req && ph) begin
                    state_nx = CH_STOP;
                    cnt_nx   = '0;
                end
            end
            CH_STOP: begin
                cnt_nx = cnt_inc(cnt);
                if (cnt >= POST_LAST) begin
                    state_nx = CH_OFF;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = CH_OFF;
                cnt_nx   = '0;
            end
        endcase
    end

    // The last ODT stage is gated with the upcoming oe so termination never fights the driver.
    always_comb begin
        oe_nx     = (state_nx != CH_OFF);
        odt_nx    = '0;
        odt_nx[0] = odt_req;
        for (int k = 1; k < ODT_DLY; k++) begin
            odt_nx[k] = odt_pipe[k-1];
        end
        odt_nx[ODT_DLY-1] = odt_nx[ODT_DLY-1] & ~oe_nx;
    end

    assign pad_odt  = odt_pipe[ODT_DLY-1];
    assign in_trans = (state == CH_START) || (state == CH_STOP);

endmodule

// File: rtl/bw_io_ddr_mclk_ctl.sv
// DDR memory-clock pad control: shared phase bit, NCH channel instances and
// the impedance-code update handshake that waits for all channels to be quiet.
module bw_io_ddr_mclk_ctl
    import bw_io_ddr_mclk_pkg::*;
#(
    parameter int             NCH      = 2,
    parameter int             CBW      = 8,
    parameter int             PRE_CYC  = 4,
    parameter int             POST_CYC = 2,
    parameter int             ODT_DLY  = 2,
    parameter logic [CBW-1:0] RST_CODE = 8'h0F
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic [NCH-1:0] en_req,
    input  logic [NCH-1:0] odt_req,
    input  logic           upd_req,
    input  logic [CBW-1:0] cbu_in,
    input  logic [CBW-1:0] cbd_in,
    output logic [NCH-1:0] pad_data,
    output logic [NCH-1:0] pad_oe,
    output logic [NCH-1:0] pad_odt,
    output logic [CBW-1:0] cbu,
    output logic [CBW-1:0] cbd,
    output logic           upd_busy,
    output logic           upd_ack,
    output logic [NCH-1:0] ch_run
);

    logic           ph;
    logic [NCH-1:0] ch_trans;
    logic [CBW-1:0] sh_cbu, sh_cbd;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ph <= 1'b0;
        end else begin
            ph <= ~ph;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        bw_io_ddr_mclk_ch #(
            .PRE_CYC  (PRE_CYC),
            .POST_CYC (POST_CYC),
            .ODT_DLY  (ODT_DLY)
        ) u_ch (
            .clk      (clk),
            .rst_l    (rst_l),
            .ph       (ph),
            .en_req   (en_req[i]),
            .odt_req  (odt_req[i]),
            .pad_data (pad_data[i]),
            .pad_oe   (pad_oe[i]),
            .pad_odt  (pad_odt[i]),
            .ch_run   (ch_run[i]),
            .in_trans (ch_trans[i])
        );
    end

    // Codes change only while no channel is in a preamble or postamble.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sh_cbu   <= RST_CODE;
            sh_cbd   <= RST_CODE;
            cbu      <= RST_CODE;
            cbd      <= RST_CODE;
            upd_busy <= 1'b0;
            upd_ack  <= 1'b0;
        end else begin
            upd_ack <= 1'b0;
            if (!upd_busy) begin
                if (upd_req) begin
                    sh_cbu   <= cbu_in;
                    sh_cbd   <= cbd_in;
                    upd_busy <= 1'b1;
                end
            end else if (~|ch_trans) begin
                cbu      <= sh_cbu;
                cbd      <= sh_cbd;
                upd_ack  <= 1'b1;
                upd_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bw_io_ddr_mclk_ctl.sv
// Directed bench for bw_io_ddr_mclk_ctl with default parameters (NCH=2).
// Cycle numbers count rising edges since the last reset release.
module tb_bw_io_ddr_mclk_ctl;

    logic       clk = 1'b0;
    logic       rst_l;
    logic [1:0] en_req, odt_req;
    logic       upd_req;
    logic [7:0] cbu_in, cbd_in;
    logic [1:0] pad_data, pad_oe, pad_odt, ch_run;
    logic [7:0] cbu, cbd;
    logic       upd_busy, upd_ack;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    bw_io_ddr_mclk_ctl dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .en_req   (en_req),
        .odt_req  (odt_req),
        .upd_req  (upd_req),
        .cbu_in   (cbu_in),
        .cbd_in   (cbd_in),
        .pad_data (pad_data),
        .pad_oe   (pad_oe),
        .pad_odt  (pad_odt),
        .cbu      (cbu),
        .cbd      (cbd),
        .upd_busy (upd_busy),
        .upd_ack  (upd_ack),
        .ch_run   (ch_run)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic test_reset();
        rst_l   = 1'b0;
        en_req  = 2'b00;
        odt_req = 2'b00;
        upd_req = 1'b0;
        cbu_in  = 8'h00;
        cbd_in  = 8'h00;
        repeat (3) step();
        n_cmp++;
        if ({pad_oe, pad_data, pad_odt, ch_run, upd_busy, upd_ack} !== 10'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctl: got %b want %b",
                     {pad_oe, pad_data, pad_odt, ch_run, upd_busy, upd_ack}, 10'b0);
        end
        n_cmp++;
        if ({cbu, cbd} !== 16'h0F0F) begin
            n_fail++;
            $display("[TB] FAIL reset_codes: got %h want %h", {cbu, cbd}, 16'h0F0F);
        end
        rst_l = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_start();
        logic [2:0] exp_v [8];
        exp_v = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b101, 3'b111, 3'b101};
        go_to(10);
        n_cmp++;
        if (pad_oe[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL start_idle_oe: got %b want 0", pad_oe[0]);
        end
        en_req[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if ({pad_oe[0], pad_data[0], ch_run[0]} !== exp_v[i]) begin
                n_fail++;
                $display("[TB] FAIL start_c%0d oe/data/run: got %b want %b",
                         cyc, {pad_oe[0], pad_data[0], ch_run[0]}, exp_v[i]);
            end
        end
    endtask

    task automatic test_stop();
        logic [2:0] exp_v [4];
        exp_v = '{3'b111, 3'b100, 3'b100, 3'b000};
        en_req[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({pad_oe[0], pad_data[0], ch_run[0]} !== exp_v[i]) begin
                n_fail++;
                $display("[TB] FAIL stop_c%0d oe/data/run: got %b want %b",
                         cyc, {pad_oe[0], pad_data[0], ch_run[0]}, exp_v[i]);
            end
        end
    endtask

    task automatic test_odt();
        odt_req[1] = 1'b1;
        step();
        n_cmp++;
        if (pad_odt[1] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL odt_early: got %b want 0", pad_odt[1]);
        end
        step();
        n_cmp++;
        if (pad_odt[1] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL odt_delay2: got %b want 1", pad_odt[1]);
        end
        en_req[1] = 1'b1;
        step();
        n_cmp++;
        if ({pad_oe[1], pad_odt[1]} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL odt_gate oe/odt: got %b want 10", {pad_oe[1], pad_odt[1]});
        end
    endtask

    task automatic test_update_blocked();
        logic [17:0] exp_v [6];
        int          acks;
        exp_v = '{{2'b10, 16'h0F0F}, {2'b10, 16'h0F0F}, {2'b10, 16'h0F0F},
                  {2'b10, 16'h0F0F}, {2'b01, 16'h3C55}, {2'b00, 16'h3C55}};
        upd_req = 1'b1;
        cbu_in  = 8'h3C;
        cbd_in  = 8'h55;
        step();
        acks = (upd_ack === 1'b1) ? 1 : 0;
        n_cmp++;
        if ({upd_busy, upd_ack, cbu} !== {2'b10, 8'h0F}) begin
            n_fail++;
            $display("[TB] FAIL upd_capture busy/ack/cbu: got %b/%b/%h want 1/0/0f",
                     upd_busy, upd_ack, cbu);
        end
        cbu_in = 8'hFF;
        cbd_in = 8'hAA;
        step();
        upd_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            if (upd_ack === 1'b1) acks++;
            n_cmp++;
            if ({upd_busy, upd_ack, cbu, cbd} !== exp_v[i]) begin
                n_fail++;
                $display("[TB] FAIL upd_c%0d busy/ack/cbu/cbd: got %b/%b/%h/%h want %h",
                         cyc, upd_busy, upd_ack, cbu, cbd, exp_v[i]);
            end
            if (cyc == 30) begin
                n_cmp++;
                if ({ch_run[1], pad_odt[1]} !== 2'b10) begin
                    n_fail++;
                    $display("[TB] FAIL run1_odt run/odt: got %b want 10", {ch_run[1], pad_odt[1]});
                end
            end
        end
        n_cmp++;
        if (acks !== 1) begin
            n_fail++;
            $display("[TB] FAIL upd_ack_count: got %0d want 1", acks);
        end
    endtask

    task automatic test_mid_reset();
        go_to(33);
        en_req[0] = 1'b1;
        step();
        n_cmp++;
        if (pad_oe !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_oe: got %b want 11", pad_oe);
        end
        upd_req = 1'b1;
        cbu_in  = 8'h77;
        cbd_in  = 8'h77;
        step();
        upd_req = 1'b0;
        n_cmp++;
        if ({upd_busy, cbu} !== {1'b1, 8'h3C}) begin
            n_fail++;
            $display("[TB] FAIL pending_upd busy/cbu: got %b/%h want 1/3c", upd_busy, cbu);
        end
        #2;
        rst_l   = 1'b0;
        en_req  = 2'b00;
        odt_req = 2'b00;
        #1;
        n_cmp++;
        if ({pad_oe, pad_data, pad_odt, ch_run, upd_busy, upd_ack, cbu, cbd} !== {10'b0, 16'h0F0F}) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %b/%h/%h want 0/0f/0f",
                     {pad_oe, pad_data, pad_odt, ch_run, upd_busy, upd_ack}, cbu, cbd);
        end
        repeat (2) step();
        rst_l = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({pad_oe, pad_data, pad_odt, ch_run, upd_busy, upd_ack, cbu, cbd} !== {10'b0, 16'h0F0F}) begin
                n_fail++;
                $display("[TB] FAIL post_reset_c%0d: got %b/%h/%h want 0/0f/0f",
                         cyc, {pad_oe, pad_data, pad_odt, ch_run, upd_busy, upd_ack}, cbu, cbd);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_v [10];
        exp_v = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                  3'b101, 3'b111, 3'b100, 3'b100, 3'b000};
        en_req[0] = 1'b1;
        step();
        en_req[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            n_cmp++;
            if ({pad_oe[0], pad_data[0], ch_run[0]} !== exp_v[i]) begin
                n_fail++;
                $display("[TB] FAIL short_en_c%0d oe/data/run: got %b want %b",
                         cyc, {pad_oe[0], pad_data[0], ch_run[0]}, exp_v[i]);
            end
        end
    endtask

    task automatic test_update_idle();
        upd_req = 1'b1;
        cbu_in  = 8'hA5;
        cbd_in  = 8'h5A;
        step();
        upd_req = 1'b0;
        n_cmp++;
        if ({upd_busy, upd_ack, cbu} !== {2'b10, 8'h0F}) begin
            n_fail++;
            $display("[TB] FAIL idle_upd_c1 busy/ack/cbu: got %b/%b/%h want 1/0/0f",
                     upd_busy, upd_ack, cbu);
        end
        step();
        n_cmp++;
        if ({upd_busy, upd_ack, cbu, cbd} !== {2'b01, 16'hA55A}) begin
            n_fail++;
            $display("[TB] FAIL idle_upd_c2 busy/ack/cbu/cbd: got %b/%b/%h/%h want 0/1/a5/5a",
                     upd_busy, upd_ack, cbu, cbd);
        end
        step();
        n_cmp++;
        if (upd_ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_upd_c3 ack: got %b want 0", upd_ack);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_stop();
        test_odt();
        test_update_blocked();
        test_mid_reset();
        test_back_to_back();
        test_update_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/bw_io_ddr_mclk_ctl.md
BW_IO_DDR_MCLK_CTL -- requirements
Module: bw_io_ddr_mclk_ctl

Interface
REQ-001 SHALL have parameter NCH, default 2, number of memory-clock pad channels (1..8).
REQ-002 SHALL have parameter CBW, default 8, width of the pull-up and pull-down impedance codes.
REQ-003 SHALL have parameter PRE_CYC, default 4, number of data-low preamble cycles before toggling (1..15).
REQ-004 SHALL have parameter POST_CYC, default 2, number of data-low postamble cycles before tristate (1..15).
REQ-005 SHALL have parameter ODT_DLY, default 2, ODT request pipeline delay in cycles (1..7).
REQ-006 SHALL have parameter RST_CODE, default 8'h0F, reset value of cbu and cbd.
REQ-007 SHALL have port clk, input, 1, the single block clock.
REQ-008 SHALL have port rst_l, input, 1, reset; asynchronous, active-low.
REQ-009 SHALL have port en_req, input, NCH, per-channel clock-enable request (level).
REQ-010 SHALL have port odt_req, input, NCH, per-channel ODT request (level).
REQ-011 SHALL have ports upd_req, input, 1, impedance-update request pulse; cbu_in, input, CBW, new pull-up code; cbd_in, input, CBW, new pull-down code.
REQ-012 SHALL have ports pad_data, output, NCH; pad_oe, output, NCH; pad_odt, output, NCH; all are per-channel pad driver controls.
REQ-013 SHALL have ports cbu, output, CBW, and cbd, output, CBW, the applied impedance codes.
REQ-014 SHALL have ports upd_busy, output, 1, update pending; upd_ack, output, 1, one-cycle pulse when a code is applied; ch_run, output, NCH, channel in RUN.

Function
REQ-015 SHALL keep a global phase bit ph, reset 0, that toggles every clk cycle.
REQ-016 SHALL implement a per-channel FSM with states OFF, START, RUN and STOP, held in registers.
REQ-017 SHALL, in OFF, drive pad_oe=0 and pad_data=0, and go to START on the first cycle en_req=1.
REQ-018 SHALL, in START, drive pad_oe=1 and pad_data=0 for at least PRE_CYC cycles (4-bit counter), and then go to RUN on the first cycle with ph=1.
REQ-019 SHALL, in RUN, drive pad_oe=1 and pad_data=ph, and assert ch_run.
REQ-020 SHALL, in RUN, go to STOP when en_req=0 on a cycle with ph=1; otherwise it stays in RUN, so the last high half is never truncated.
REQ-021 SHALL, in STOP, drive pad_oe=1 and pad_data=0 for POST_CYC cycles, then go to OFF regardless of en_req; re-entry to START follows from OFF.
REQ-022 SHALL, if en_req drops during START, complete the preamble, enter RUN, and immediately apply the rule in REQ-020.
REQ-023 SHALL produce pad_odt[i] as odt_req[i] delayed by exactly ODT_DLY registers, forced to 0 in any cycle where pad_oe[i]=1.
REQ-024 SHALL, on upd_req=1 with upd_busy=0, capture cbu_in and cbd_in into shadow registers and set upd_busy on the next cycle.
REQ-025 SHALL ignore upd_req while upd_busy=1.
REQ-026 SHALL, while upd_busy=1, copy the shadow codes to cbu and cbd on the first cycle in which no channel is in START or STOP, pulse upd_ack for that one cycle, and clear upd_busy on the next cycle.
REQ-027 SHALL NOT apply a captured code in the same cycle it is captured; the minimum request-to-ack latency is 1 cycle.
REQ-028 SHALL register every output; no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, while rst_l=0, force all channels to OFF and hold pad_oe=0, pad_data=0, pad_odt=0, the ODT pipeline=0, ch_run=0, ph=0, upd_busy=0, upd_ack=0, and cbu=cbd=shadow=RST_CODE.
REQ-030 SHALL abort any in-progress preamble, postamble or pending update when reset asserts mid-operation, with no ack issued.

Structure
REQ-031 SHALL place the FSM state enum (OFF/START/RUN/STOP) and the counter width constant in package bw_io_ddr_mclk_pkg.
REQ-032 SHALL implement the per-channel FSM, counter and ODT pipeline as sub-module bw_io_ddr_mclk_ch, instantiated NCH times; ph and the update logic stay in the top module.

Verification
REQ-033 SHALL cover basic start: NCH=2, en_req[0] rises at cycle 10 -> pad_oe[0]=1 at 11; pad_data[0]=0 for >=4 cycles; toggling begins with 0 on the first cycle after ph=1; ch_run[0]=1.
REQ-034 SHALL cover stop: en_req[0] falls while pad_data[0]=0 -> one more high cycle, then 2 low cycles with oe=1, then pad_oe[0]=0.
REQ-035 SHALL cover update blocking: upd_req with cbu_in=8'h3C while ch1 is in START -> upd_busy=1, cbu stays 8'h0F until ch1 enters RUN, then cbu=8'h3C with a single upd_ack.
REQ-036 SHALL cover ODT: odt_req[1]=1 with ch1 OFF -> pad_odt[1]=1 exactly 2 cycles later; it drops to 0 while pad_oe[1]=1.
REQ-037 SHALL cover ignored requests: a second upd_req with cbd_in=8'hAA while busy -> ignored, and cbd takes the first request's value.
REQ-038 SHALL cover mid-run reset: rst_l low while in RUN -> pad_oe=0 and cbu=cbd=8'h0F asynchronously; after release, all channels OFF.
